// File: rtl/commit_trace_buf_if.sv
// Commit-trace port bundle: CPU commit/register-write inputs, trace FIFO head outputs and status.
// master = CPU/consumer side, slave = trace buffer.
interface commit_trace_buf_if;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        gr_we;
    logic [4:0]  gr_waddr;
    logic [31:0] gr_wdata;
    logic        trace_ready;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        trace_rwe;
    logic [4:0]  trace_rd;
    logic [31:0] trace_rdata;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    modport master (
        output pc, inst, gr_we, gr_waddr, gr_wdata, trace_ready,
        input  trace_valid, trace_pc, trace_inst, trace_rwe, trace_rd, trace_rdata,
        input  count, overflow, drop_cnt
    );

    modport slave (
        input  pc, inst, gr_we, gr_waddr, gr_wdata, trace_ready,
        output trace_valid, trace_pc, trace_inst, trace_rwe, trace_rd, trace_rdata,
        output count, overflow, drop_cnt
    );
endinterface

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: detects pc changes as commits and queues {pc, inst[, reg write]} records.
// Define TRACE_REGWR_EN to attach the pending register write to each record.
module commit_trace_buf #(
    parameter int DEPTH = 8
) (
    input logic               clk_in,
    input logic               reset,
    commit_trace_buf_if.slave bus
);
`ifdef TRACE_REGWR_EN
    localparam int W = 102;
`else
    localparam int W = 64;
`endif
    localparam int AW = $clog2(DEPTH);

    // Handshake: trace_valid = occupancy != 0; a record is consumed on any edge with
    // trace_valid && trace_ready. Head data is stable until consumed.
    logic [31:0]   pc_prev;
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rec;
    logic [W-1:0]  head;
    logic [W-1:0]  last_head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic          commit;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    assign commit = (bus.pc != pc_prev);
    assign full   = (count == 5'(DEPTH));
    assign pop    = (count != 5'd0) && bus.trace_ready;
    assign push   = commit && (!full || pop);
    assign drop   = commit && full && !pop;

`ifdef TRACE_REGWR_EN
    logic        pend_we;
    logic [4:0]  pend_rd;
    logic [31:0] pend_data;
    logic        wr_qual;

    assign wr_qual = bus.gr_we && (bus.gr_waddr != 5'd0);

    // A write in the commit cycle itself bypasses the pending registers.
    always_comb begin
        rec = {bus.pc, bus.inst, pend_we, pend_rd, pend_data};
        if (wr_qual) begin
            rec = {bus.pc, bus.inst, 1'b1, bus.gr_waddr, bus.gr_wdata};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset || commit) begin
            pend_we   <= 1'b0;
            pend_rd   <= 5'd0;
            pend_data <= 32'd0;
        end else if (wr_qual) begin
            pend_we   <= 1'b1;
            pend_rd   <= bus.gr_waddr;
            pend_data <= bus.gr_wdata;
        end
    end

    assign bus.trace_rwe   = head[37];
    assign bus.trace_rd    = head[36:32];
    assign bus.trace_rdata = head[31:0];
`else
    logic unused_gr;
    assign unused_gr       = ^{bus.gr_we, bus.gr_waddr, bus.gr_wdata};
    assign rec             = {bus.pc, bus.inst};
    assign bus.trace_rwe   = 1'b0;
    assign bus.trace_rd    = 5'd0;
    assign bus.trace_rdata = 32'd0;
`endif

    // When empty, the outputs show the most recently consumed head (zero after reset).
    assign head = (count != 5'd0) ? mem[rd_ptr] : last_head;

    assign bus.trace_valid = (count != 5'd0);
    assign bus.trace_pc    = head[W-1 -: 32];
    assign bus.trace_inst  = head[W-33 -: 32];
    assign bus.count       = count;
    assign bus.overflow    = overflow;
    assign bus.drop_cnt    = drop_cnt;

    always_ff @(posedge clk_in) begin
        if (!reset && push) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            pc_prev   <= 32'hFFFF_FFFF;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= 5'd0;
            overflow  <= 1'b0;
            drop_cnt  <= 16'd0;
            last_head <= '0;
        end else begin
            pc_prev <= bus.pc;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_head <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 5'd1;
            end else if (pop && !push) begin
                count <= count - 5'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end
endmodule
